// File: rtl/calc_seq_ctrl.sv
// Sequencing controller for the 4-digit BCD add/subtract calculator ALU.
// Builds operands from keypad codes, launches the ALU, captures the result and drives the display.

module bcd_digit_carry (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic       cout
);
    logic [4:0] raw;

    assign raw  = {1'b0, a} + {1'b0, b} + {4'b0, cin};
    assign cout = (raw > 5'd9);
endmodule

module calc_seq_ctrl #(
    parameter int ALU_LAT = 2
) (
    input  logic        clk,
    input  logic        clear_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] alu_bcd_a,
    output logic [15:0] alu_bcd_b,
    output logic [3:0]  alu_op,
    output logic        alu_clear,
    input  logic [15:0] alu_result,
    input  logic        alu_neg,
    output logic [15:0] disp_bcd,
    output logic        disp_neg,
    output logic        err,
    output logic        busy,
    output logic        done
);
    localparam int NUM_DIGITS = 4;
    localparam int CW = (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

    localparam logic [3:0] OP_IDLE = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        WAIT_ALU,
        SHOW_RES,
        ERROR
    } state_t;

    state_t state, state_n;

    logic          key_vld_q;
    logic [3:0]    key_code_q;
    logic [15:0]   a, a_n, b, b_n, res, res_n;
    logic [2:0]    a_cnt, a_cnt_n, b_cnt, b_cnt_n;
    logic          op_sub, op_sub_n;
    logic          res_neg, res_neg_n;
    logic [CW-1:0] wait_cnt, wait_cnt_n;

    logic [3:0]    alu_op_n;
    logic [15:0]   disp_bcd_n;
    logic          disp_neg_n, err_n, done_n;

    logic is_digit, is_op, is_eq, is_clr;

    assign is_digit = key_vld_q && (key_code_q <= 4'h9);
    assign is_op    = key_vld_q && ((key_code_q == 4'hA) || (key_code_q == 4'hB));
    assign is_eq    = key_vld_q && (key_code_q == 4'hC);
    assign is_clr   = key_vld_q && (key_code_q == 4'hE);

    assign alu_bcd_a = a;
    assign alu_bcd_b = b;

    // Decimal carry chain over A+B; the ALU's own result is not trusted for overflow.
    logic [NUM_DIGITS:0] carry;
    logic                add_ovf;

    assign carry[0] = 1'b0;
    assign add_ovf  = carry[NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dig
        bcd_digit_carry u_dig (
            .a    (a[4*g +: 4]),
            .b    (b[4*g +: 4]),
            .cin  (carry[g]),
            .cout (carry[g+1])
        );
    end

    always_comb begin
        state_n    = state;
        a_n        = a;
        b_n        = b;
        a_cnt_n    = a_cnt;
        b_cnt_n    = b_cnt;
        op_sub_n   = op_sub;
        res_n      = res;
        res_neg_n  = res_neg;
        wait_cnt_n = wait_cnt;

        if (is_clr) begin
            state_n   = ENTER_A;
            a_n       = '0;
            b_n       = '0;
            a_cnt_n   = '0;
            b_cnt_n   = '0;
            op_sub_n  = 1'b0;
            res_n     = '0;
            res_neg_n = 1'b0;
        end else begin
            case (state)
                ENTER_A: begin
                    if (is_digit && a_cnt != 3'd4) begin
                        a_n     = {a[11:0], key_code_q};
                        a_cnt_n = a_cnt + 3'd1;
                    end else if (is_op) begin
                        op_sub_n = (key_code_q == 4'hB);
                        b_n      = '0;
                        b_cnt_n  = '0;
                        state_n  = ENTER_B;
                    end
                end
                ENTER_B: begin
                    if (is_digit && b_cnt != 3'd4) begin
                        b_n     = {b[11:0], key_code_q};
                        b_cnt_n = b_cnt + 3'd1;
                    end else if (is_op && b_cnt == 3'd0) begin
                        op_sub_n = (key_code_q == 4'hB);
                    end else if (is_eq) begin
                        wait_cnt_n = '0;
                        state_n    = WAIT_ALU;
                    end
                end
                WAIT_ALU: begin
                    if (wait_cnt == CW'(ALU_LAT)) begin
                        res_n     = alu_result;
                        res_neg_n = alu_neg;
                        state_n   = (!op_sub && add_ovf) ? ERROR : SHOW_RES;
                    end else begin
                        wait_cnt_n = wait_cnt + CW'(1);
                    end
                end
                SHOW_RES: begin
                    if (is_digit) begin
                        a_n     = {12'h000, key_code_q};
                        a_cnt_n = 3'd1;
                        b_n     = '0;
                        b_cnt_n = '0;
                        state_n = ENTER_A;
                    end else if (is_op && !res_neg) begin
                        // Chain: the previous result becomes a full-width operand A.
                        a_n      = res;
                        a_cnt_n  = 3'd4;
                        op_sub_n = (key_code_q == 4'hB);
                        b_n      = '0;
                        b_cnt_n  = '0;
                        state_n  = ENTER_B;
                    end
                end
                ERROR: begin
                    if (is_digit) begin
                        a_n       = {12'h000, key_code_q};
                        a_cnt_n   = 3'd1;
                        b_n       = '0;
                        b_cnt_n   = '0;
                        op_sub_n  = 1'b0;
                        res_n     = '0;
                        res_neg_n = 1'b0;
                        state_n   = ENTER_A;
                    end
                end
                default: state_n = ENTER_A;
            endcase
        end
    end

    // Output decode of the upcoming state so every output is a flop.
    always_comb begin
        alu_op_n   = (state_n == WAIT_ALU) ? (op_sub_n ? OP_SUB : OP_ADD) : OP_IDLE;
        disp_bcd_n = '0;
        disp_neg_n = 1'b0;
        err_n      = 1'b0;
        done_n     = (state == WAIT_ALU) && ((state_n == SHOW_RES) || (state_n == ERROR));
        case (state_n)
            ENTER_A:           disp_bcd_n = a_n;
            ENTER_B, WAIT_ALU: disp_bcd_n = (b_cnt_n != 3'd0) ? b_n : a_n;
            SHOW_RES: begin
                disp_bcd_n = res_n;
                disp_neg_n = res_neg_n;
            end
            ERROR:             err_n = 1'b1;
            default:           disp_bcd_n = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            key_vld_q  <= 1'b0;
            key_code_q <= '0;
            state      <= ENTER_A;
            a          <= '0;
            b          <= '0;
            a_cnt      <= '0;
            b_cnt      <= '0;
            op_sub     <= 1'b0;
            res        <= '0;
            res_neg    <= 1'b0;
            wait_cnt   <= '0;
            alu_op     <= OP_IDLE;
            alu_clear  <= 1'b1;
            disp_bcd   <= '0;
            disp_neg   <= 1'b0;
            err        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            key_vld_q  <= key_valid;
            key_code_q <= key_code;
            state      <= state_n;
            a          <= a_n;
            b          <= b_n;
            a_cnt      <= a_cnt_n;
            b_cnt      <= b_cnt_n;
            op_sub     <= op_sub_n;
            res        <= res_n;
            res_neg    <= res_neg_n;
            wait_cnt   <= wait_cnt_n;
            alu_op     <= alu_op_n;
            alu_clear  <= (state_n != WAIT_ALU);
            disp_bcd   <= disp_bcd_n;
            disp_neg   <= disp_neg_n;
            err        <= err_n;
            busy       <= (state_n == WAIT_ALU);
            done       <= done_n;
        end
    end
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Directed bench for calc_seq_ctrl with a small pipelined BCD ALU stub.

module tb_calc_seq_ctrl;
    localparam int LAT = 2;

    logic        clk;
    logic        clear_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] alu_bcd_a, alu_bcd_b, alu_result, disp_bcd;
    logic [3:0]  alu_op;
    logic        alu_clear, alu_neg, disp_neg, err, busy, done;

    int checks = 0;
    int failures = 0;

    calc_seq_ctrl #(.ALU_LAT(LAT)) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .alu_bcd_a  (alu_bcd_a),
        .alu_bcd_b  (alu_bcd_b),
        .alu_op     (alu_op),
        .alu_clear  (alu_clear),
        .alu_result (alu_result),
        .alu_neg    (alu_neg),
        .disp_bcd   (disp_bcd),
        .disp_neg   (disp_neg),
        .err        (err),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stub: result is LAT clocks behind its inputs; outputs 0 when idle.
    function automatic int b2i(input logic [15:0] v);
        return int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic [15:0] i2b(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    int          ai, bi;
    logic [15:0] m_res;
    logic        m_neg;
    logic [15:0] p_res [LAT];
    logic        p_neg [LAT];

    always_comb begin
        ai    = b2i(alu_bcd_a);
        bi    = b2i(alu_bcd_b);
        m_res = 16'h0;
        m_neg = 1'b0;
        if (alu_op == 4'b0001) begin
            m_res = i2b((ai + bi) % 10000);
        end else if (alu_op == 4'b0010) begin
            if (ai >= bi) m_res = i2b(ai - bi);
            else begin
                m_res = i2b(bi - ai);
                m_neg = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        p_res[0] <= m_res;
        p_neg[0] <= m_neg;
        for (int i = 1; i < LAT; i++) begin
            p_res[i] <= p_res[i-1];
            p_neg[i] <= p_neg[i-1];
        end
    end

    assign alu_result = p_res[LAT-1];
    assign alu_neg    = p_neg[LAT-1];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Press equals and check busy window, done pulse and displayed result.
    task automatic run_eq(input string tag, input logic [3:0] exp_op, input logic [15:0] exp_disp,
                          input logic exp_neg, input logic exp_err);
        press(4'hC);
        for (int i = 0; i <= LAT; i++) begin
            @(negedge clk);
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_op"}, 32'(alu_op), 32'(exp_op));
            chk({tag, "_aluclr"}, 32'(alu_clear), 32'd0);
            chk({tag, "_done_early"}, 32'(done), 32'd0);
        end
        @(negedge clk);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_busy_off"}, 32'(busy), 32'd0);
        chk({tag, "_op_idle"}, 32'(alu_op), 32'd0);
        chk({tag, "_aluclr_on"}, 32'(alu_clear), 32'd1);
        chk({tag, "_disp"}, 32'(disp_bcd), 32'(exp_disp));
        chk({tag, "_neg"}, 32'(disp_neg), 32'(exp_neg));
        chk({tag, "_err"}, 32'(err), 32'(exp_err));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        clear_n   = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        repeat (2) @(negedge clk);
        chk("rst_op", 32'(alu_op), 32'd0);
        chk("rst_aluclr", 32'(alu_clear), 32'd1);
        chk("rst_disp", 32'(disp_bcd), 32'd0);
        chk("rst_neg", 32'(disp_neg), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        clear_n = 1'b1;

        // 1234 + 5678
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); tick();
        chk("t1_dispA", 32'(disp_bcd), 32'h1234);
        press(4'hA); tick();
        chk("t1_dispB0", 32'(disp_bcd), 32'h1234);
        press(4'h5); press(4'h6); press(4'h7); press(4'h8); tick();
        chk("t1_dispB", 32'(disp_bcd), 32'h5678);
        chk("t1_opA", 32'(alu_bcd_a), 32'h1234);
        chk("t1_opB", 32'(alu_bcd_b), 32'h5678);
        run_eq("t1", 4'b0001, 16'h6912, 1'b0, 1'b0);

        // 12 - 34, with an ignored operator after B digits
        press(4'h1); press(4'h2); press(4'hB); press(4'h3); press(4'h4); press(4'hA);
        run_eq("t2", 4'b0010, 16'h0022, 1'b1, 1'b0);

        // 9999 + 0001 overflows
        press(4'h9); press(4'h9); press(4'h9); press(4'h9); press(4'hA);
        press(4'h0); press(4'h0); press(4'h0); press(4'h1);
        run_eq("t3", 4'b0001, 16'h0000, 1'b0, 1'b1);
        press(4'h7); tick();
        chk("t3_recover_err", 32'(err), 32'd0);
        chk("t3_recover_disp", 32'(disp_bcd), 32'h0007);

        // fifth digit ignored, operator replaced before B digits
        press(4'hE); tick();
        chk("t4_clr_disp", 32'(disp_bcd), 32'h0);
        press(4'hD); tick();
        chk("t4_ignD", 32'(disp_bcd), 32'h0);
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5); tick();
        chk("t4_5th", 32'(disp_bcd), 32'h1234);
        press(4'hA); press(4'hB); tick();
        chk("t4_B0disp", 32'(disp_bcd), 32'h1234);
        chk("t4_idle_op", 32'(alu_op), 32'd0);
        press(4'h1); tick();
        chk("t4_Bdisp", 32'(disp_bcd), 32'h0001);
        run_eq("t4", 4'b0010, 16'h1233, 1'b0, 1'b0);

        // chaining: 5+3=8, then +2
        press(4'h5); press(4'hA); press(4'h3);
        run_eq("t5a", 4'b0001, 16'h0008, 1'b0, 1'b0);
        press(4'hA); tick();
        chk("t5_chainA", 32'(alu_bcd_a), 32'h0008);
        chk("t5_chain_disp", 32'(disp_bcd), 32'h0008);
        press(4'h2);
        run_eq("t5b", 4'b0001, 16'h0010, 1'b0, 1'b0);

        // clear_n during WAIT_ALU
        press(4'h1); press(4'hA); press(4'h2); press(4'hC);
        @(negedge clk);
        chk("t6_busy", 32'(busy), 32'd1);
        clear_n = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
        chk("t6_op", 32'(alu_op), 32'd0);
        chk("t6_aluclr", 32'(alu_clear), 32'd1);
        chk("t6_disp", 32'(disp_bcd), 32'd0);
        chk("t6_neg", 32'(disp_neg), 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        chk("t6_busy_off", 32'(busy), 32'd0);
        chk("t6_done", 32'(done), 32'd0);
        chk("t6_a", 32'(alu_bcd_a), 32'd0);
        chk("t6_b", 32'(alu_bcd_b), 32'd0);
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clk);
            chk("t6_nodone", 32'(done), 32'd0);
            chk("t6_nobusy", 32'(busy), 32'd0);
        end

        // clear-all key in ENTER_B returns to ENTER_A
        press(4'h4); press(4'hA); press(4'h5); tick();
        chk("t7_dispB", 32'(disp_bcd), 32'h0005);
        press(4'hE); tick();
        chk("t7_clr_disp", 32'(disp_bcd), 32'h0);
        chk("t7_clr_busy", 32'(busy), 32'd0);
        press(4'h6); tick();
        chk("t7_dispA", 32'(disp_bcd), 32'h0006);
        press(4'hC);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t7_eq_ignored", 32'(busy), 32'd0);
        end
        chk("t7_op_idle", 32'(alu_op), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
